timer_irq_regfile: RTL and testbench

//  Parametrised interrupt-mask (TIMSKn) / interrupt-flag (TIFRn) register file shared by NUM_TIMERS timers.

---
 rtl/timer_irq_regfile_pkg.sv | 18 +
 rtl/timer_irq_regfile_if.sv | 33 +++
 rtl/timer_irq_regfile_channel.sv | 44 ++++
 rtl/timer_irq_regfile.sv | 79 +++++++
 tb/tb_timer_irq_regfile.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_irq_regfile_pkg.sv
// timer_irq_regfile_pkg: register select encoding, flag bit positions and width helper
package timer_irq_regfile_pkg;

    // Low address bit picks the register within a timer
    typedef enum logic {SEL_TIMSK = 1'b0, SEL_TIFR = 1'b1} reg_sel_e;

    // Flag bit positions: TOV is bit 0 for every timer, OCF sits at bit 1 on timer0 and bit 4 on timer1
    typedef enum int {TOV_BIT = 0, OCF0_BIT = 1, OCF1_BIT = 4} flag_bit_e;

    // Ceiling log2, never below 1 so derived buses always have a legal width
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/timer_irq_regfile_if.sv
// timer_irq_regfile_if: CPU register bus, timer flag pulses and interrupt request/acknowledge
//   master (CPU/timer side): drives reg_addr, reg_wr_en, reg_wr_data, flag_set, gie, irq_ack
//   slave  (register file) : drives reg_rd_data, irq_valid, irq_vector
interface timer_irq_regfile_if #(
    parameter int NUM_TIMERS = 2,
    parameter int FLAG_BITS  = 8
);
    import timer_irq_regfile_pkg::*;

    localparam int ADDR_W = clog2(2 * NUM_TIMERS);
    localparam int VEC_W  = clog2(NUM_TIMERS * FLAG_BITS);

    logic [ADDR_W-1:0]               reg_addr;
    logic                            reg_wr_en;
    logic [FLAG_BITS-1:0]            reg_wr_data;
    logic [FLAG_BITS-1:0]            reg_rd_data;
    logic [NUM_TIMERS*FLAG_BITS-1:0] flag_set;
    logic                            gie;
    logic                            irq_valid;
    logic [VEC_W-1:0]                irq_vector;
    logic                            irq_ack;

    modport master (
        output reg_addr, reg_wr_en, reg_wr_data, flag_set, gie, irq_ack,
        input  reg_rd_data, irq_valid, irq_vector
    );

    modport slave (
        input  reg_addr, reg_wr_en, reg_wr_data, flag_set, gie, irq_ack,
        output reg_rd_data, irq_valid, irq_vector
    );

endinterface

// File: rtl/timer_irq_regfile_channel.sv
// timer_irq_channel: one timer's TIMSK/TIFR pair with hardware set, write-1-to-clear and ack clear
//   sysClock, system_reset : clock, synchronous active-high reset
//   i_mask_we, i_flag_we   : TIMSK load / TIFR write-1-to-clear strobes
//   i_wr_data              : CPU write data
//   i_flag_set, i_ack_clr  : per-bit hardware set pulses and acknowledge clear
//   o_mask, o_flag         : current register values for readback
//   o_pend                 : next-state flags qualified by next-state mask
module timer_irq_channel
    import timer_irq_regfile_pkg::*;
#(
    parameter int FLAG_BITS = 8
) (
    input  logic                 sysClock,
    input  logic                 system_reset,
    input  logic                 i_mask_we,
    input  logic                 i_flag_we,
    input  logic [FLAG_BITS-1:0] i_wr_data,
    input  logic [FLAG_BITS-1:0] i_flag_set,
    input  logic [FLAG_BITS-1:0] i_ack_clr,
    output logic [FLAG_BITS-1:0] o_mask,
    output logic [FLAG_BITS-1:0] o_flag,
    output logic [FLAG_BITS-1:0] o_pend
);
    logic [FLAG_BITS-1:0] r_mask, r_flag, w_nxt_mask, w_nxt_flag;

    assign w_nxt_mask = i_mask_we ? i_wr_data : r_mask;
    // A set pulse wins over any coincident clear of the same bit
    assign w_nxt_flag = i_flag_set | (r_flag & ~(i_flag_we ? i_wr_data : '0) & ~i_ack_clr);

    always_ff @(posedge sysClock) begin
        if (system_reset) begin
            r_mask <= '0;
            r_flag <= '0;
        end else begin
            r_mask <= w_nxt_mask;
            r_flag <= w_nxt_flag;
        end
    end

    assign o_mask = r_mask;
    assign o_flag = r_flag;
    assign o_pend = w_nxt_flag & w_nxt_mask;

endmodule

// File: rtl/timer_irq_regfile.sv
// timer_irq_regfile: TIMSK/TIFR register file for NUM_TIMERS timers with one prioritised interrupt request
//   sysClock, system_reset : clock, synchronous active-high reset
//   bus (slave)            : register read/write, flag set pulses, gie, irq valid/vector/ack
module timer_irq_regfile
    import timer_irq_regfile_pkg::*;
#(
    parameter int NUM_TIMERS = 2,
    parameter int FLAG_BITS  = 8
) (
    input  logic              sysClock,
    input  logic              system_reset,
    timer_irq_regfile_if.slave bus
);
    localparam int ADDR_W = clog2(2 * NUM_TIMERS);
    localparam int VEC_W  = clog2(NUM_TIMERS * FLAG_BITS);
    localparam int NB     = NUM_TIMERS * FLAG_BITS;

    logic [ADDR_W-1:0]    w_tidx;
    reg_sel_e             w_sel;
    logic [FLAG_BITS-1:0] w_mask [NUM_TIMERS];
    logic [FLAG_BITS-1:0] w_flag [NUM_TIMERS];
    logic [NB-1:0]        w_pend, w_gated, w_ack;
    logic [VEC_W-1:0]     w_vec, r_irq_vector;
    logic                 r_irq_valid;
    logic [FLAG_BITS-1:0] w_rd_data;

    assign w_tidx = bus.reg_addr >> 1;
    assign w_sel  = reg_sel_e'(bus.reg_addr[0]);
    // Acknowledge only clears the flag currently presented, and only while a request is up
    assign w_ack  = (bus.irq_ack && r_irq_valid) ? (NB'(1) << r_irq_vector) : '0;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
        logic w_hit;
        assign w_hit = bus.reg_wr_en && (w_tidx == ADDR_W'(g));
        timer_irq_channel #(.FLAG_BITS(FLAG_BITS)) u_ch (
            .sysClock     (sysClock),
            .system_reset (system_reset),
            .i_mask_we    (w_hit && (w_sel == SEL_TIMSK)),
            .i_flag_we    (w_hit && (w_sel == SEL_TIFR)),
            .i_wr_data    (bus.reg_wr_data),
            .i_flag_set   (bus.flag_set[g*FLAG_BITS +: FLAG_BITS]),
            .i_ack_clr    (w_ack[g*FLAG_BITS +: FLAG_BITS]),
            .o_mask       (w_mask[g]),
            .o_flag       (w_flag[g]),
            .o_pend       (w_pend[g*FLAG_BITS +: FLAG_BITS])
        );
    end

    // Unimplemented timer indices match no channel and read back as zero
    always_comb begin
        w_rd_data = '0;
        for (int t = 0; t < NUM_TIMERS; t++)
            if (w_tidx == ADDR_W'(t)) w_rd_data = (w_sel == SEL_TIFR) ? w_flag[t] : w_mask[t];
    end

    assign bus.reg_rd_data = w_rd_data;
    assign w_gated = w_pend & {NB{bus.gie}};

    // Descending scan leaves the lowest pending index; with nothing pending the vector holds
    always_comb begin
        w_vec = r_irq_vector;
        for (int i = NB - 1; i >= 0; i--)
            if (w_gated[i]) w_vec = VEC_W'(i);
    end

    always_ff @(posedge sysClock) begin
        if (system_reset) begin
            r_irq_valid  <= 1'b0;
            r_irq_vector <= '0;
        end else begin
            r_irq_valid  <= |w_gated;
            r_irq_vector <= w_vec;
        end
    end

    assign bus.irq_valid  = r_irq_valid;
    assign bus.irq_vector = r_irq_vector;

endmodule

// File: tb/tb_timer_irq_regfile.sv
// tb_timer_irq_regfile: self-checking bench for timer_irq_regfile with three timers
module tb_timer_irq_regfile;
    import timer_irq_regfile_pkg::*;

    localparam int NT = 3;
    localparam int FB = 8;
    localparam int NB = NT * FB;
    localparam int AW = 3;
    localparam int VW = 5;

    typedef struct {
        string       tag;
        logic [15:0] val;
        int          src;
    } exp_t;

    logic sysClock = 1'b0;
    logic system_reset;
    always #5 sysClock = ~sysClock;

    timer_irq_regfile_if #(.NUM_TIMERS(NT), .FLAG_BITS(FB)) bus ();

    timer_irq_regfile #(.NUM_TIMERS(NT), .FLAG_BITS(FB)) dut (
        .sysClock     (sysClock),
        .system_reset (system_reset),
        .bus          (bus.slave)
    );

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [FB-1:0] m_mask [NT];
    logic [FB-1:0] m_flag [NT];
    logic          m_valid;
    logic [VW-1:0] m_vec;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] model_rd();
        int tidx;
        tidx = int'(bus.reg_addr) / 2;
        if (tidx >= NT) return '0;
        return bus.reg_addr[0] ? m_flag[tidx] : m_mask[tidx];
    endfunction

    task automatic model_step();
        logic [FB-1:0] nm [NT];
        logic [FB-1:0] nf [NT];
        logic [NB-1:0] pend;
        int            tidx;
        bit            sel, clr;
        tidx = int'(bus.reg_addr) / 2;
        sel  = bus.reg_addr[0];
        if (system_reset) begin
            for (int t = 0; t < NT; t++) begin
                m_mask[t] = '0;
                m_flag[t] = '0;
            end
            m_valid = 1'b0;
            m_vec   = '0;
        end else begin
            pend = '0;
            for (int t = 0; t < NT; t++) begin
                nm[t] = (bus.reg_wr_en && tidx == t && !sel) ? bus.reg_wr_data : m_mask[t];
                for (int b = 0; b < FB; b++) begin
                    clr = (bus.reg_wr_en && tidx == t && sel && bus.reg_wr_data[b])
                       || (bus.irq_ack && m_valid && int'(m_vec) == t * FB + b);
                    nf[t][b] = bus.flag_set[t*FB+b] || (m_flag[t][b] && !clr);
                    pend[t*FB+b] = nf[t][b] && nm[t][b] && bus.gie;
                end
            end
            m_valid = |pend;
            for (int i = 0; i < NB; i++)
                if (pend[i]) begin
                    m_vec = VW'(i);
                    break;
                end
            for (int t = 0; t < NT; t++) begin
                m_mask[t] = nm[t];
                m_flag[t] = nf[t];
            end
        end
        sb.push_back('{tag: "irq_valid", val: 16'(m_valid), src: 0});
        sb.push_back('{tag: "irq_vector", val: 16'(m_vec), src: 1});
        sb.push_back('{tag: "rd_data", val: 16'(model_rd()), src: 2});
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge sysClock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, e.src == 0 ? 16'(bus.irq_valid) : e.src == 1 ? 16'(bus.irq_vector) : 16'(bus.reg_rd_data), e.val);
        end
        bus.flag_set  = '0;
        bus.reg_wr_en = 1'b0;
        bus.irq_ack   = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [FB-1:0] d);
        bus.reg_addr    = a;
        bus.reg_wr_data = d;
        bus.reg_wr_en   = 1'b1;
        cycle();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [FB-1:0] exp, input string tag);
        bus.reg_addr = a;
        #1;
        check(tag, 16'(bus.reg_rd_data), 16'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        system_reset    = 1'b1;
        bus.reg_addr    = '0;
        bus.reg_wr_en   = 1'b0;
        bus.reg_wr_data = '0;
        bus.flag_set    = '0;
        bus.gie         = 1'b0;
        bus.irq_ack     = 1'b0;

        // Reset held two cycles against all-ones set pulses
        for (int k = 0; k < 2; k++) begin
            bus.flag_set = '1;
            cycle();
        end
        system_reset = 1'b0;
        for (int a = 0; a < 2 * NT; a++) rd(AW'(a), 8'h00, "rst_reg");
        check("rst_valid", 16'(bus.irq_valid), 16'h0);
        check("rst_vector", 16'(bus.irq_vector), 16'h0);

        // Set under mask raises the request one cycle later
        wr(3'd0, 8'h02);
        bus.gie = 1'b1;
        bus.flag_set[int'(OCF0_BIT)] = 1'b1;
        cycle();
        rd(3'd1, 8'h02, "set_tifr0");
        check("set_valid", 16'(bus.irq_valid), 16'h1);
        check("set_vector", 16'(bus.irq_vector), 16'h1);

        // Write-1-to-clear, write-0 no-op, set beating coincident clear, read-before-write
        bus.flag_set[int'(TOV_BIT)] = 1'b1;
        cycle();
        rd(3'd1, 8'h03, "w1c_pre");
        wr(3'd1, 8'h01);
        rd(3'd1, 8'h02, "w1c_bit0");
        wr(3'd1, 8'h00);
        rd(3'd1, 8'h02, "w1c_zero");
        bus.flag_set[int'(OCF0_BIT)] = 1'b1;
        wr(3'd1, 8'h02);
        rd(3'd1, 8'h02, "w1c_set_wins");
        bus.reg_addr    = 3'd0;
        bus.reg_wr_data = 8'h55;
        bus.reg_wr_en   = 1'b1;
        #1;
        check("rd_old", 16'(bus.reg_rd_data), 16'h02);
        cycle();
        rd(3'd0, 8'h55, "rd_new");

        // Priority and acknowledge across timers
        wr(3'd1, 8'hff);
        wr(3'd0, 8'h01);
        wr(3'd2, 8'h10);
        bus.flag_set[FB + int'(OCF1_BIT)] = 1'b1;
        cycle();
        check("pri_t1", 16'(bus.irq_vector), 16'(FB + int'(OCF1_BIT)));
        bus.flag_set[int'(TOV_BIT)] = 1'b1;
        cycle();
        check("pri_t0", 16'(bus.irq_vector), 16'h0);
        bus.irq_ack = 1'b1;
        cycle();
        rd(3'd1, 8'h00, "ack_tifr0");
        check("ack_next_valid", 16'(bus.irq_valid), 16'h1);
        check("ack_next_vector", 16'(bus.irq_vector), 16'(FB + int'(OCF1_BIT)));
        bus.irq_ack = 1'b1;
        cycle();
        check("ack_last_valid", 16'(bus.irq_valid), 16'h0);
        check("ack_vec_hold", 16'(bus.irq_vector), 16'(FB + int'(OCF1_BIT)));
        rd(3'd3, 8'h00, "ack_tifr1");

        // Global enable gating and ignored acknowledge
        bus.gie = 1'b0;
        bus.flag_set[int'(TOV_BIT)] = 1'b1;
        cycle();
        check("gie_off_valid", 16'(bus.irq_valid), 16'h0);
        rd(3'd1, 8'h01, "gie_off_flag");
        bus.irq_ack = 1'b1;
        cycle();
        rd(3'd1, 8'h01, "ack_ignored");
        bus.gie = 1'b1;
        cycle();
        check("gie_on_valid", 16'(bus.irq_valid), 16'h1);
        check("gie_on_vector", 16'(bus.irq_vector), 16'h0);
        wr(3'd0, 8'h00);
        check("mask_drop", 16'(bus.irq_valid), 16'h0);

        // Out-of-range decode and reset while a request is up
        wr(3'd0, 8'h01);
        check("pre_rst_valid", 16'(bus.irq_valid), 16'h1);
        wr(3'd6, 8'hff);
        wr(3'd7, 8'hff);
        rd(3'd6, 8'h00, "oob_timsk");
        rd(3'd7, 8'h00, "oob_tifr");
        rd(3'd0, 8'h01, "oob_keep_timsk");
        rd(3'd1, 8'h01, "oob_keep_tifr");
        system_reset = 1'b1;
        cycle();
        system_reset = 1'b0;
        check("mid_rst_valid", 16'(bus.irq_valid), 16'h0);
        check("mid_rst_vector", 16'(bus.irq_vector), 16'h0);
        for (int a = 0; a < 2 * NT; a++) rd(AW'(a), 8'h00, "mid_rst_reg");

        // Random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            bus.reg_addr    = AW'($urandom_range(0, 7));
            bus.reg_wr_en   = ($urandom_range(0, 3) == 0);
            bus.reg_wr_data = FB'($urandom);
            bus.flag_set    = NB'($urandom & $urandom & $urandom);
            bus.gie         = ($urandom_range(0, 7) != 0);
            bus.irq_ack     = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
